axil_wr_ctrl: RTL and testbench

//  AXI4-Lite write-channel controller in front of the slave memory array. Accepts AW and W in either order or

---
 rtl/axil_pkg.sv | 29 ++
 rtl/axil_chan_hold.sv | 26 ++
 rtl/axil_wr_ctrl.sv | 158 +++++++++++++++
 tb/tb_axil_wr_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types, response codes and the byte-strobe mask helper for the AXI4-Lite write controller.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HAVE_ADDR,
    ST_HAVE_DATA,
    ST_WRITE,
    ST_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest data bus the mask helper serves; callers zero-extend and truncate around it.
  localparam int unsigned AXIL_MAX_DW = 256;
  localparam int unsigned AXIL_MAX_SW = AXIL_MAX_DW / 8;

  function automatic logic [AXIL_MAX_DW-1:0] strb_mask(input logic [AXIL_MAX_DW-1:0] data,
                                                      input logic [AXIL_MAX_SW-1:0] strb);
    logic [AXIL_MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(AXIL_MAX_SW); i++) begin
      if (strb[i]) m[i*8 +: 8] = data[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/axil_chan_hold.sv
// One-entry holding register with a full flag; captures a channel payload on load, empties on clear.
module axil_chan_hold #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q    <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_wr_ctrl.sv
// AXI4-Lite write-channel controller: joins AW and W in any order, issues one masked memory write, returns B.
// Optional word-index range check (SLVERR) is enabled by defining AXIL_WR_RANGE_CHK_EN.
module axil_wr_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 12
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [ADDR_WIDTH-1:0]                         AWADDR,
  input  logic                                          AWVALID,
  output logic                                          AWREADY,
  input  logic [DATA_WIDTH-1:0]                         WDATA,
  input  logic [DATA_WIDTH/8-1:0]                       WSTRB,
  input  logic                                          WVALID,
  output logic                                          WREADY,
  output logic                                          BVALID,
  output logic [1:0]                                    BRESP,
  input  logic                                          BREADY,
  output logic                                          wr_en,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0]                         wr_data_masked,
  output logic [DATA_WIDTH/8-1:0]                       wr_strb
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFS    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFS;

`ifdef AXIL_WR_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  wr_state_t state_q, state_d;

  logic              aw_hs, w_hs;
  logic              aw_full, w_full, hold_clr;
  logic              have_aw, have_w, addr_err;
  logic [IDX_W-1:0]  aw_idx_q, sel_idx;
  logic [DATA_WIDTH-1:0] w_data_q, sel_data;
  logic [STRB_W-1:0] w_strb_q, sel_strb;

  logic              awready_d, wready_d, bvalid_d, wr_en_d;
  logic [1:0]        bresp_d;
  logic [IDX_W-1:0]  wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [STRB_W-1:0] wr_strb_d;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // Low address bits only pick a byte lane and are deliberately ignored.
  if (OFS > 0) begin : g_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^AWADDR[OFS-1:0];
  end

  axil_chan_hold #(.W(IDX_W)) u_aw_hold (
    .CLK   (CLK),
    .RST   (RST),
    .load  (aw_hs),
    .clear (hold_clr),
    .d     (AWADDR[ADDR_WIDTH-1:OFS]),
    .q     (aw_idx_q),
    .full  (aw_full)
  );

  axil_chan_hold #(.W(DATA_WIDTH + STRB_W)) u_w_hold (
    .CLK   (CLK),
    .RST   (RST),
    .load  (w_hs),
    .clear (hold_clr),
    .d     ({WDATA, WSTRB}),
    .q     ({w_data_q, w_strb_q}),
    .full  (w_full)
  );

  // The completing beat may still be on the bus, so prefer held values and fall back to live inputs.
  assign sel_idx  = aw_full ? aw_idx_q : AWADDR[ADDR_WIDTH-1:OFS];
  assign sel_data = w_full  ? w_data_q : WDATA;
  assign sel_strb = w_full  ? w_strb_q : WSTRB;
  assign have_aw  = aw_full || aw_hs;
  assign have_w   = w_full || w_hs;
  assign addr_err = RANGE_CHK && (32'(sel_idx) >= MEM_DEPTH);

  // Next state and next registered output values.
  always_comb begin
    state_d   = state_q;
    bresp_d   = BRESP;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data_masked;
    wr_strb_d = wr_strb;
    hold_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HAVE_ADDR, ST_HAVE_DATA: begin
        if (have_aw && have_w) begin
          state_d = ST_WRITE;
          bresp_d = addr_err ? RESP_SLVERR : RESP_OKAY;
          if (!addr_err) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_idx;
            wr_data_d = DATA_WIDTH'(strb_mask(AXIL_MAX_DW'(sel_data), AXIL_MAX_SW'(sel_strb)));
            wr_strb_d = sel_strb;
          end
        end else if (have_aw) begin
          state_d = ST_HAVE_ADDR;
        end else if (have_w) begin
          state_d = ST_HAVE_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d  = ST_RESP;
        hold_clr = 1'b1;
      end
      ST_RESP: begin
        if (BVALID && BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    awready_d = (state_d == ST_IDLE) || (state_d == ST_HAVE_DATA);
    wready_d  = (state_d == ST_IDLE) || (state_d == ST_HAVE_ADDR);
    bvalid_d  = (state_d == ST_RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      AWREADY        <= 1'b0;
      WREADY         <= 1'b0;
      BVALID         <= 1'b0;
      BRESP          <= RESP_OKAY;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data_masked <= '0;
      wr_strb        <= '0;
    end else begin
      state_q        <= state_d;
      AWREADY        <= awready_d;
      WREADY         <= wready_d;
      BVALID         <= bvalid_d;
      BRESP          <= bresp_d;
      wr_en          <= wr_en_d;
      wr_addr        <= wr_addr_d;
      wr_data_masked <= wr_data_d;
      wr_strb        <= wr_strb_d;
    end
  end

endmodule

// File: tb/tb_axil_wr_ctrl.sv
// Self-checking bench for axil_wr_ctrl: directed table, reset corner cases, randomized transactions.
module tb_axil_wr_ctrl;

`ifdef AXIL_WR_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [5:0]  AWADDR;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data_masked;
  logic [3:0]  wr_strb;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [3:0]  exp_idx;
    logic [31:0] exp_masked;
    logic [1:0]  exp_resp;
    bit          exp_wr;
  } txn_t;

  axil_wr_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .AWADDR         (AWADDR),
    .AWVALID        (AWVALID),
    .AWREADY        (AWREADY),
    .WDATA          (WDATA),
    .WSTRB          (WSTRB),
    .WVALID         (WVALID),
    .WREADY         (WREADY),
    .BVALID         (BVALID),
    .BRESP          (BRESP),
    .BREADY         (BREADY),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data_masked (wr_data_masked),
    .wr_strb        (wr_strb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({AWREADY, WREADY, BVALID, BRESP, wr_en, wr_addr, wr_data_masked, wr_strb});
  endfunction

  // Reference: word index, byte-masked data and response follow directly from address and strobes.
  function automatic txn_t model_txn(input logic [5:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb, input int awd, input int wd, input int bd);
    txn_t t;
    bit   oob;
    t.addr = addr; t.data = data; t.strb = strb;
    t.aw_dly = awd; t.w_dly = wd; t.b_dly = bd;
    t.exp_idx = 4'(addr / 6'd4);
    t.exp_masked = 32'h0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) t.exp_masked = t.exp_masked | (data & (32'hFF << (8 * b)));
    oob = (int'(addr) / 4) >= 12;
    t.exp_wr   = !(CHK && oob);
    t.exp_resp = (CHK && oob) ? 2'b10 : 2'b00;
    return t;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    tick();
    chk("reset_outs", all_outs(), 64'h0);
    RST = 1'b0;
    chk("reset_outs_after", all_outs(), 64'h0);
    tick();
    tick();
  endtask

  // Drives one transaction with the given channel delays and checks timing, payload and response.
  task automatic run_txn(input txn_t t);
    bit aw_done, w_done, b_done;
    int aw_c, w_c, wr_c, bv_c, b_c, wr_cnt, last;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  r;
    aw_done = 0; w_done = 0; b_done = 0;
    aw_c = -1; w_c = -1; wr_c = -1; bv_c = -1; b_c = -1; wr_cnt = 0;
    a = '0; d = '0; s = '0; r = '0;
    last = (t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly;
    AWADDR = t.addr; WDATA = t.data; WSTRB = t.strb;
    for (int cyc = 0; cyc < 100 && !b_done; cyc++) begin
      if (wr_en) begin
        wr_cnt++; wr_c = cyc; a = wr_addr; d = wr_data_masked; s = wr_strb;
      end
      if (bv_c >= 0) begin
        chk("resp_hold", 64'({BVALID, BRESP, AWREADY, WREADY}), 64'({1'b1, t.exp_resp, 2'b00}));
      end
      if (BVALID && bv_c < 0) begin
        bv_c = cyc; r = BRESP;
      end
      if (aw_done && !w_done) chk("have_addr_ready", 64'({AWREADY, WREADY}), 64'h1);
      if (w_done && !aw_done) chk("have_data_ready", 64'({AWREADY, WREADY}), 64'h2);
      AWVALID = !aw_done && (cyc >= t.aw_dly);
      WVALID  = !w_done && (cyc >= t.w_dly);
      BREADY  = (bv_c >= 0) && (cyc >= bv_c + t.b_dly);
      if (AWVALID && AWREADY) begin aw_done = 1; aw_c = cyc; end
      if (WVALID && WREADY)   begin w_done = 1; w_c = cyc; end
      if (BVALID && BREADY)   begin b_done = 1; b_c = cyc; end
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    chk("b_done", 64'(b_done), 64'h1);
    chk("post_idle", 64'({AWREADY, WREADY, BVALID}), 64'h6);
    chk("aw_accept_cyc", 64'(aw_c), 64'(t.aw_dly));
    chk("w_accept_cyc", 64'(w_c), 64'(t.w_dly));
    chk("wr_en_count", 64'(wr_cnt), 64'(t.exp_wr));
    if (t.exp_wr) begin
      chk("wr_en_cyc", 64'(wr_c), 64'(last + 1));
      chk("wr_addr", 64'(a), 64'(t.exp_idx));
      chk("wr_data_masked", 64'(d), 64'(t.exp_masked));
      chk("wr_strb", 64'(s), 64'(t.strb));
    end
    chk("bvalid_cyc", 64'(bv_c), 64'(last + 2));
    chk("bresp", 64'(r), 64'(t.exp_resp));
    chk("b_accept_cyc", 64'(b_c), 64'(bv_c + t.b_dly));
  endtask

  initial begin
    txn_t tbl[8];
    txn_t rt;
    int   evt;

    tbl[0] = '{6'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 4'd4,  32'hDEADBEEF, 2'b00, 1'b1};
    tbl[1] = '{6'h20, 32'h12345678, 4'h3, 3, 0, 0, 4'd8,  32'h00005678, 2'b00, 1'b1};
    tbl[2] = '{6'h04, 32'hAABBCCDD, 4'h8, 0, 2, 0, 4'd1,  32'hAA000000, 2'b00, 1'b1};
    tbl[3] = '{6'h08, 32'h0F0F0F0F, 4'h5, 1, 1, 5, 4'd2,  32'h000F000F, 2'b00, 1'b1};
    tbl[4] = '{6'h30, 32'h11111111, 4'hF, 0, 0, 0, 4'd12, 32'h11111111, CHK ? 2'b10 : 2'b00, !CHK};
    tbl[5] = '{6'h2C, 32'h55AA55AA, 4'h0, 1, 0, 1, 4'd11, 32'h00000000, 2'b00, 1'b1};
    tbl[6] = '{6'h13, 32'hCAFEF00D, 4'h6, 0, 1, 2, 4'd4,  32'h00FEF000, 2'b00, 1'b1};
    tbl[7] = '{6'h3F, 32'h87654321, 4'hF, 2, 1, 1, 4'd15, 32'h87654321, CHK ? 2'b10 : 2'b00, !CHK};

    RST = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    do_reset();
    chk("idle_ready", 64'({AWREADY, WREADY}), 64'h3);

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset while an address is held: it must be dropped, so a lone W afterwards cannot complete a write.
    AWADDR = 6'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("rst_seq_have_addr", 64'({AWREADY, WREADY}), 64'h1);
    RST = 1'b1;
    tick();
    chk("rst_mid_outs", all_outs(), 64'h0);
    RST = 1'b0;
    chk("rst_mid_outs_after", all_outs(), 64'h0);
    tick();
    chk("rst_mid_idle", 64'({AWREADY, WREADY}), 64'h3);
    WDATA = 32'h01020304; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    evt = 0;
    for (int c = 0; c < 6; c++) begin
      if (wr_en || BVALID) evt++;
      tick();
    end
    chk("rst_no_write", 64'(evt), 64'h0);
    chk("rst_w_only_ready", 64'({AWREADY, WREADY}), 64'h2);
    do_reset();

    for (int n = 0; n < 40; n++) begin
      rt = model_txn(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_txn(rt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
